// File: rtl/nc_frac_decimator.sv
// Averaging decimator for the MASH o_frac stream: flush a settling interval, then sum 2^P_WIN_LOG2 samples.
// Optional NC_DEC_RANGE_EN adds min/max tracking and an out-of-range sticky flag over the window.
module nc_frac_decimator #(
    parameter int unsigned P_WIN_LOG2 = 10,
    parameter int unsigned P_FLUSH    = 16,
    parameter int unsigned P_SUM_W    = P_WIN_LOG2 + 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [3:0]                i_frac,
    input  logic                      i_valid,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic signed [P_SUM_W-1:0] o_sum
`ifdef NC_DEC_RANGE_EN
    ,
    output logic signed [3:0]         o_min,
    output logic signed [3:0]         o_max,
    output logic                      o_range_err
`endif
);

    // Counter must reach both the flush length and the window length
    localparam int unsigned CNT_W = (P_WIN_LOG2 + 1 > 8) ? P_WIN_LOG2 + 1 : 8;
    localparam logic [CNT_W-1:0] FLUSH_LAST = (P_FLUSH > 0) ? CNT_W'(P_FLUSH - 1) : '0;
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'((1 << P_WIN_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_ACCUM
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [P_SUM_W-1:0]  acc_q, acc_d;
    logic signed [P_SUM_W-1:0]  sum_d;
    logic signed [P_SUM_W-1:0]  sample;
    logic                       busy_d;
    logic                       done_d;

    assign sample = {{(P_SUM_W-4){i_frac[3]}}, i_frac};

`ifdef NC_DEC_RANGE_EN
    localparam logic signed [3:0] MIN_INIT = 4'sb0111;
    localparam logic signed [3:0] MAX_INIT = 4'sb1000;
    localparam logic signed [3:0] LEGAL_LO = 4'sb1101;
    localparam logic signed [3:0] LEGAL_HI = 4'sb0100;

    logic signed [3:0] frac_s;
    logic signed [3:0] min_d, max_d;
    logic              err_d;

    assign frac_s = $signed(i_frac);
`endif

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = o_sum;
        done_d  = 1'b0;
`ifdef NC_DEC_RANGE_EN
        min_d   = o_min;
        max_d   = o_max;
        err_d   = o_range_err;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (P_FLUSH > 0) ? S_FLUSH : S_ACCUM;
`ifdef NC_DEC_RANGE_EN
                    min_d   = MIN_INIT;
                    max_d   = MAX_INIT;
                    err_d   = 1'b0;
`endif
                end
            end
            S_FLUSH: begin
                if (i_valid) begin
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (i_valid) begin
                    acc_d = acc_q + sample;
`ifdef NC_DEC_RANGE_EN
                    if (frac_s < o_min) min_d = frac_s;
                    if (frac_s > o_max) max_d = frac_s;
                    if ((frac_s < LEGAL_LO) || (frac_s > LEGAL_HI)) err_d = 1'b1;
`endif
                    if (cnt_q == WIN_LAST) begin
                        sum_d   = acc_q + sample;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
            o_sum   <= sum_d;
        end
    end

`ifdef NC_DEC_RANGE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_min       <= MIN_INIT;
            o_max       <= MAX_INIT;
            o_range_err <= 1'b0;
        end else begin
            o_min       <= min_d;
            o_max       <= max_d;
            o_range_err <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_nc_frac_decimator.sv
// Randomized bench for nc_frac_decimator: two instances (flush 2 and flush 0) share stimulus and are
// checked every cycle against a sample-counting reference model.
module tb_nc_frac_decimator;

    localparam int unsigned WIN   = 4;
    localparam int          N     = 16;
    localparam int unsigned SUM_W = WIN + 4;
    localparam int          FL0   = 2;
    localparam int          FL1   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       valid;
    logic [3:0] frac;

    logic                    busy [2];
    logic                    done [2];
    logic signed [SUM_W-1:0] sum  [2];
`ifdef NC_DEC_RANGE_EN
    logic signed [3:0] mn  [2];
    logic signed [3:0] mx  [2];
    logic              err [2];
    int exp_mn [2];
    int exp_mx [2];
    int exp_err[2];
`endif

    nc_frac_decimator #(.P_WIN_LOG2(WIN), .P_FLUSH(FL0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_frac(frac), .i_valid(valid), .i_start(start),
        .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum[0])
`ifdef NC_DEC_RANGE_EN
        , .o_min(mn[0]), .o_max(mx[0]), .o_range_err(err[0])
`endif
    );

    nc_frac_decimator #(.P_WIN_LOG2(WIN), .P_FLUSH(FL1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_frac(frac), .i_valid(valid), .i_start(start),
        .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum[1])
`ifdef NC_DEC_RANGE_EN
        , .o_min(mn[1]), .o_max(mx[1]), .o_range_err(err[1])
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int flush   [2];
    int last_sum[2];

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_range(input int d);
`ifdef NC_DEC_RANGE_EN
        exp_mn[d]  = 7;
        exp_mx[d]  = -8;
        exp_err[d] = 0;
`endif
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            last_sum[d] = 0;
            clear_range(d);
        end
    endtask

    task automatic check_outputs(input int d, input int exp_busy, input int exp_done);
        check($sformatf("busy%0d", d), busy[d], exp_busy);
        check($sformatf("done%0d", d), done[d], exp_done);
        check($sformatf("sum%0d", d), $signed(sum[d]), last_sum[d]);
`ifdef NC_DEC_RANGE_EN
        check($sformatf("min%0d", d), $signed(mn[d]), exp_mn[d]);
        check($sformatf("max%0d", d), $signed(mx[d]), exp_mx[d]);
        check($sformatf("rerr%0d", d), err[d], exp_err[d]);
`endif
    endtask

    // mode 0: const +1; 1: +4/-3 with valid toggling; 2: random; 3: random + stray start; 4: one -5
    task automatic run_meas(input int mode, input int rst_at);
        int v;
        int steps;
        int s;
        int exp_done;
        int acc[2];
        bit fin[2];
        v = 0;
        steps = 0;
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0;
            fin[d] = 1'b0;
            clear_range(d);
        end
        start = 1'b1;
        valid = 1'($urandom_range(1));
        frac  = 4'($urandom_range(15));
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 2; d++) check_outputs(d, 1, 0);
        while (!(fin[0] && fin[1])) begin
            steps++;
            if (steps > 300) begin
                check("timeout", 0, 1);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                reset_model();
                return;
            end
            case (mode)
                0: begin valid = 1'b1; frac = 4'd1; end
                1: begin valid = (steps % 2) == 1; frac = ((v % 2) == 0) ? 4'd4 : 4'hD; end
                3: begin valid = 1'b1; frac = 4'($urandom_range(15)); end
                4: begin valid = 1'b1; frac = (steps == FL0 + 3) ? 4'hB : 4'd1; end
                default: begin valid = ($urandom_range(3) != 0); frac = 4'($urandom_range(15)); end
            endcase
            start = (mode == 3) && (steps == FL0 + 5);
            rst   = (rst_at > 0) && (steps == rst_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                reset_model();
                for (int d = 0; d < 2; d++) check_outputs(d, 0, 0);
                return;
            end
            s = int'($signed(frac));
            if (valid) v++;
            for (int d = 0; d < 2; d++) begin
                exp_done = 0;
                if (!fin[d] && valid && v > flush[d]) begin
                    acc[d] += s;
`ifdef NC_DEC_RANGE_EN
                    if (s < exp_mn[d]) exp_mn[d] = s;
                    if (s > exp_mx[d]) exp_mx[d] = s;
                    if (s < -3 || s > 4) exp_err[d] = 1;
`endif
                    if (v == flush[d] + N) begin
                        fin[d]      = 1'b1;
                        exp_done    = 1;
                        last_sum[d] = acc[d];
                        if (mode == 0) check($sformatf("latency%0d", d), steps + 1, 1 + flush[d] + N);
                    end
                end
                check_outputs(d, fin[d] ? 0 : 1, exp_done);
            end
        end
    endtask

    initial begin
        flush[0] = FL0;
        flush[1] = FL1;
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        frac  = 4'd0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) check_outputs(d, 0, 0);

        run_meas(0, 0);
        run_meas(1, 0);
        run_meas(3, 0);
        run_meas(4, 0);
        for (int i = 0; i < 6; i++) run_meas(2, 0);
        run_meas(3, 10);
        run_meas(2, 0);

        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        reset_model();
        for (int d = 0; d < 2; d++) check_outputs(d, 0, 0);
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            frac  = 4'($urandom_range(15));
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) check_outputs(d, 0, 0);
        end
        run_meas(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
